perceptron_trainer: RTL and testbench
=====================================

Name: perceptron_trainer

Overview:
- Sequencing controller that trains the fixed-point 4-sample parallel neuron (int_neuro datapath: sign-magnitude Q3.12, 1 sign, 3 integer, 12 fraction bits).
- Drives w0/w1/w2 into the neuron and walks samples 0..N-1 once per epoch.
- Compares each sample's neuron result with the desired output and applies the perceptron rule online, one sample at a time.
- Stops on a zero-error epoch (converged) or at MAX_EPOCH.

Parameters:
W, 16, word width (sign-magnitude)
FRAC, 12, fraction bits; ONE = 1 << FRAC = 0x1000
N, 4, samples per epoch (neuron parallelism)
MAX_EPOCH, 32, epoch limit
SETTLE, 2, wait cycles after a weight change before sampling the neuron result (>= 1)
LR_SHIFT, 1, learning rate = 2^-LR_SHIFT, applied as a magnitude right shift

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  begin training; honoured only in IDLE
init_w0, init_w1, init_w2  in  W each  initial weights, loaded on an accepted start
in1, in2  in  N*W  sample inputs, packed, sample k at [k*W +: W]; held stable while busy
d  in  N*W  desired outputs, packed, each either 0x0000 or ONE
result  in  N*W  neuron outputs, packed, from the int_neuro instance
w0, w1, w2  out  W each  current weights, fed to the neuron
busy  out  1  training in progress
done  out  1  one-cycle pulse at end of training
converged  out  1  last run ended with a zero-error epoch; held until the next accepted start
epoch_count  out  clog2(MAX_EPOCH+1)  epochs completed
err_count  out  clog2(N+1)  mismatches in the current or last epoch

Behaviour:
- Reset: state IDLE; w0/w1/w2 = 0; busy, done, converged = 0; epoch_count = err_count = 0; sample index k = 0; settle counter = 0.
- States: IDLE, SETTLE, EVAL, EPOCH_END, DONE.
- IDLE, start=1:
  - Load init_w*; clear epoch_count, err_count, converged.
  - k = 0; counter = SETTLE; go SETTLE. busy = 1 from the next cycle.
- SETTLE: decrement counter each cycle; go EVAL when the counter reaches 1. SETTLE therefore lasts exactly SETTLE cycles.
- EVAL (one cycle, compares result[k] with d[k], full word):
  - Match: no weight change.
  - Mismatch: err_count += 1. e = +1 if d[k] != 0, else -1.
    - w0 += e*(ONE >> LR_SHIFT)
    - w1 += e*(in1[k] magnitude >> LR_SHIFT), with sign = in1 sign XOR e sign
    - w2 likewise using in2[k]
    - All three weights register simultaneously.
  - Next state: if k < N-1, k += 1, counter = SETTLE, go SETTLE; else go EPOCH_END.
- EPOCH_END (one cycle):
  - epoch_count += 1.
  - err_count == 0: converged = 1, go DONE.
  - Else, epoch_count+1 == MAX_EPOCH: go DONE with converged = 0.
  - Else: err_count = 0, k = 0, counter = SETTLE, go SETTLE.
- DONE: done = 1 for one cycle; busy = 0 from the next cycle; go IDLE. Weights and status are held.
- Timing for one epoch, start accepted at T: samples occupy T+1..T+N*(SETTLE+1), EPOCH_END at T+N*(SETTLE+1)+1, done at T+N*(SETTLE+1)+2. With defaults, done is at T+14. Each further epoch adds N*(SETTLE+1)+1 cycles.
- Arithmetic: sign-magnitude add/sub.
  - Magnitude saturates at 0x7FFF, sign preserved.
  - A zero result is always +0 (0x0000), never 0x8000.
  - Operands of -0 are treated as 0.
- start while busy (any non-IDLE state): ignored.
- rst mid-run: immediate return to reset values; no done pulse.
- in1/in2/d changing while busy: undefined training result, no hang.

Decomposition:
- Package nn_pkg: W, FRAC, ONE, MAX_MAG = 0x7FFF, state enum, helper functions sm_neg and sm_is_zero.
- Sub-module sm_addsub_sat: combinational sign-magnitude saturating add of two W-bit operands. Instantiated three times, one per weight.

Test Plan:
- OR gate, no training needed:
  - Stimulus: in1 = {0,1,0,1}, in2 = {0,0,1,1} (1 = 0x1000), d = {0,1,1,1}; init w = 0x8800, 0x0800, 0x0800 (-0.5, +0.5, +0.5). Bench neuron model: ONE if sum >= 0, else 0.
  - Required: done at T+14, converged = 1, epoch_count = 1, err_count = 0, weights unchanged.
- AND gate, trained from the OR weights, d = {0,0,0,1}, defaults:
  - Per-epoch errors 2, 3, 2, 1, 0.
  - Required: converged = 1, epoch_count = 5, w0 = 0x9800, w1 = 0x0800, w2 = 0x1000.
- XOR, MAX_EPOCH = 8:
  - Required: done after 8 epochs, converged = 0, epoch_count = 8, err_count != 0.
- sm_addsub_sat unit checks:
  - 0x7FF0 + 0x0800 -> 0x7FFF
  - 0x8800 + 0x1000 -> 0x0800
  - 0x8800 + 0x0800 -> 0x0000
  - 0xFFF0 + 0x8800 -> 0xFFFF
- Control edges:
  - start pulsed mid-epoch: ignored, results unchanged.
  - rst asserted during SETTLE of epoch 2: next cycle busy = 0, weights = 0, no done pulse.
  - A new start afterwards trains normally.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types, constants and sign-magnitude helpers for the perceptron trainer.
package nn_pkg;

    localparam int unsigned W    = 16;
    localparam int unsigned FRAC = 12;

    localparam logic [W-1:0] ONE     = W'(1 << FRAC);
    localparam logic [W-2:0] MAX_MAG = 15'h7FFF;

    localparam int unsigned ST_W = 3;
    typedef logic [ST_W-1:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_SETTLE    = 3'd1;
    localparam state_t ST_EVAL      = 3'd2;
    localparam state_t ST_EPOCH_END = 3'd3;
    localparam state_t ST_DONE      = 3'd4;

    function automatic logic sm_is_zero(input logic [W-1:0] x);
        return (x[W-2:0] == '0);
    endfunction

    // Negation never produces -0.
    function automatic logic [W-1:0] sm_neg(input logic [W-1:0] x);
        return sm_is_zero(x) ? '0 : {~x[W-1], x[W-2:0]};
    endfunction

endpackage

// File: rtl/sm_addsub_sat.sv
// Combinational sign-magnitude add with magnitude saturation; zero is always +0.
module sm_addsub_sat
    import nn_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum_c
);

    logic         sa;
    logic         sb;
    logic [W-2:0] ma;
    logic [W-2:0] mb;
    logic [W-1:0] wide;
    logic [W-2:0] mag;
    logic         sign;

    always_comb begin
        sa   = a[W-1];
        sb   = b[W-1];
        ma   = a[W-2:0];
        mb   = b[W-2:0];
        wide = '0;
        mag  = '0;
        sign = 1'b0;
        if (sa == sb) begin
            wide = {1'b0, ma} + {1'b0, mb};
            mag  = wide[W-1] ? MAX_MAG : wide[W-2:0];
            sign = sa;
        end else if (ma >= mb) begin
            mag  = ma - mb;
            sign = sa;
        end else begin
            mag  = mb - ma;
            sign = sb;
        end
        sum_c = (mag == '0) ? '0 : {sign, mag};
    end

endmodule

// File: rtl/perceptron_trainer.sv
// Online perceptron-rule training controller for a 4-sample parallel Q3.12 neuron.
module perceptron_trainer
    import nn_pkg::*;
#(
    parameter int unsigned N         = 4,
    parameter int unsigned MAX_EPOCH = 32,
    parameter int unsigned SETTLE    = 2,
    parameter int unsigned LR_SHIFT  = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [W-1:0]                     init_w0,
    input  logic [W-1:0]                     init_w1,
    input  logic [W-1:0]                     init_w2,
    input  logic [N*W-1:0]                   in1,
    input  logic [N*W-1:0]                   in2,
    input  logic [N*W-1:0]                   d,
    input  logic [N*W-1:0]                   result,
    output logic [W-1:0]                     w0,
    output logic [W-1:0]                     w1,
    output logic [W-1:0]                     w2,
    output logic                             busy,
    output logic                             done,
    output logic                             converged,
    output logic [$clog2(MAX_EPOCH+1)-1:0]   epoch_count,
    output logic [$clog2(N+1)-1:0]           err_count
);

    localparam int unsigned EW  = $clog2(MAX_EPOCH + 1);
    localparam int unsigned ECW = $clog2(N + 1);
    localparam int unsigned KW  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW  = $clog2(SETTLE + 1);
    localparam logic [W-2:0] STEP0_MAG = (W-1)'(ONE >> LR_SHIFT);

    state_t         state;
    state_t         state_nxt;
    logic [KW-1:0]  k;
    logic [KW-1:0]  k_nxt;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_nxt;
    logic [W-1:0]   w0_nxt;
    logic [W-1:0]   w1_nxt;
    logic [W-1:0]   w2_nxt;
    logic [EW-1:0]  epoch_nxt;
    logic [ECW-1:0] err_nxt;
    logic           conv_nxt;
    logic           busy_nxt;
    logic           done_nxt;

    logic [W-1:0]   res_k;
    logic [W-1:0]   d_k;
    logic [W-1:0]   in1_k;
    logic [W-1:0]   in2_k;
    logic           e_neg;
    logic           mismatch;
    logic [W-1:0]   step0;
    logic [W-1:0]   step1;
    logic [W-1:0]   step2;
    logic [W-1:0]   w0_upd_c;
    logic [W-1:0]   w1_upd_c;
    logic [W-1:0]   w2_upd_c;

    // Select the current sample's lanes.
    always_comb begin
        res_k = '0;
        d_k   = '0;
        in1_k = '0;
        in2_k = '0;
        for (int i = 0; i < N; i++) begin
            if (k == KW'(i)) begin
                res_k = result[i*W +: W];
                d_k   = d[i*W +: W];
                in1_k = in1[i*W +: W];
                in2_k = in2[i*W +: W];
            end
        end
    end

    assign e_neg    = (d_k == '0);
    assign mismatch = (res_k != d_k);
    assign step0    = e_neg ? sm_neg({1'b0, STEP0_MAG}) : {1'b0, STEP0_MAG};
    assign step1    = e_neg ? sm_neg({in1_k[W-1], in1_k[W-2:0] >> LR_SHIFT})
                            : {in1_k[W-1], in1_k[W-2:0] >> LR_SHIFT};
    assign step2    = e_neg ? sm_neg({in2_k[W-1], in2_k[W-2:0] >> LR_SHIFT})
                            : {in2_k[W-1], in2_k[W-2:0] >> LR_SHIFT};

    sm_addsub_sat u_add_w0 (.a(w0), .b(step0), .sum_c(w0_upd_c));
    sm_addsub_sat u_add_w1 (.a(w1), .b(step1), .sum_c(w1_upd_c));
    sm_addsub_sat u_add_w2 (.a(w2), .b(step2), .sum_c(w2_upd_c));

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        cnt_nxt   = cnt;
        w0_nxt    = w0;
        w1_nxt    = w1;
        w2_nxt    = w2;
        epoch_nxt = epoch_count;
        err_nxt   = err_count;
        conv_nxt  = converged;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    w0_nxt    = init_w0;
                    w1_nxt    = init_w1;
                    w2_nxt    = init_w2;
                    epoch_nxt = '0;
                    err_nxt   = '0;
                    conv_nxt  = 1'b0;
                    k_nxt     = '0;
                    cnt_nxt   = CW'(SETTLE);
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt <= CW'(1)) begin
                    state_nxt = ST_EVAL;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            ST_EVAL: begin
                if (mismatch) begin
                    err_nxt = err_count + ECW'(1);
                    w0_nxt  = w0_upd_c;
                    w1_nxt  = w1_upd_c;
                    w2_nxt  = w2_upd_c;
                end
                if (k == KW'(N - 1)) begin
                    state_nxt = ST_EPOCH_END;
                end else begin
                    k_nxt     = k + KW'(1);
                    cnt_nxt   = CW'(SETTLE);
                    state_nxt = ST_SETTLE;
                end
            end
            ST_EPOCH_END: begin
                epoch_nxt = epoch_count + EW'(1);
                if (err_count == '0) begin
                    conv_nxt  = 1'b1;
                    state_nxt = ST_DONE;
                end else if ((epoch_count + EW'(1)) == EW'(MAX_EPOCH)) begin
                    state_nxt = ST_DONE;
                end else begin
                    err_nxt   = '0;
                    k_nxt     = '0;
                    cnt_nxt   = CW'(SETTLE);
                    state_nxt = ST_SETTLE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        busy_nxt = (state_nxt != ST_IDLE);
        done_nxt = (state_nxt == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            k           <= '0;
            cnt         <= '0;
            w0          <= '0;
            w1          <= '0;
            w2          <= '0;
            epoch_count <= '0;
            err_count   <= '0;
            converged   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            k           <= k_nxt;
            cnt         <= cnt_nxt;
            w0          <= w0_nxt;
            w1          <= w1_nxt;
            w2          <= w2_nxt;
            epoch_count <= epoch_nxt;
            err_count   <= err_nxt;
            converged   <= conv_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
        end
    end

endmodule

// File: tb/tb_perceptron_trainer.sv
// Directed bench: trains OR / AND / XOR against a behavioural neuron and checks control corners.
module tb_perceptron_trainer;

    localparam int LIMIT = 400;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] init_w0;
    logic [15:0] init_w1;
    logic [15:0] init_w2;
    logic [63:0] in1;
    logic [63:0] in2;
    logic [63:0] d;
    logic [63:0] result;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [15:0] w2;
    logic        busy;
    logic        done;
    logic        converged;
    logic [3:0]  epoch_count;
    logic [2:0]  err_count;

    logic [15:0] ua;
    logic [15:0] ub;
    logic [15:0] us;

    int tests;
    int fails;

    perceptron_trainer #(
        .N(4), .MAX_EPOCH(8), .SETTLE(2), .LR_SHIFT(1)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .init_w0(init_w0), .init_w1(init_w1), .init_w2(init_w2),
        .in1(in1), .in2(in2), .d(d), .result(result),
        .w0(w0), .w1(w1), .w2(w2),
        .busy(busy), .done(done), .converged(converged),
        .epoch_count(epoch_count), .err_count(err_count)
    );

    sm_addsub_sat u_add (.a(ua), .b(ub), .sum_c(us));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sm2int(input logic [15:0] x);
        int m;
        m = int'(x[14:0]);
        return x[15] ? -m : m;
    endfunction

    // Behavioural neuron: ONE when w0 + w1*x1 + w2*x2 >= 0.
    always_comb begin
        int acc;
        result = '0;
        for (int k = 0; k < 4; k++) begin
            acc = sm2int(w0) * 4096 + sm2int(w1) * sm2int(in1[k*16 +: 16])
                + sm2int(w2) * sm2int(in2[k*16 +: 16]);
            result[k*16 +: 16] = (acc >= 0) ? 16'h1000 : 16'h0000;
        end
    end

    typedef struct {
        string             name;
        logic [3:0][15:0]  in1;
        logic [3:0][15:0]  in2;
        logic [3:0][15:0]  d;
        logic [15:0]       iw0, iw1, iw2;
        bit                conv;
        int                epochs;
        bit                chk_w;
        logic [15:0]       ew0, ew1, ew2;
        int                lat;
    } vec_t;

    typedef struct {
        logic [15:0] a, b, exp;
    } add_t;

    vec_t tbl[3];
    add_t adds[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load(input vec_t v);
        in1     = v.in1;
        in2     = v.in2;
        d       = v.d;
        init_w0 = v.iw0;
        init_w1 = v.iw1;
        init_w2 = v.iw2;
    endtask

    task automatic run_case(input int idx, input int glitch_at);
        vec_t v;
        int   lat;
        v   = tbl[idx];
        lat = 0;
        @(negedge clk);
        load(v);
        start = 1'b1;
        for (int n = 1; n <= LIMIT; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start = 1'b0;
                check({v.name, " busy after start"}, 32'(busy), 32'd1);
            end
            if (n == glitch_at) begin
                start   = 1'b1;
                init_w0 = 16'h7FFF;
                init_w1 = 16'h7FFF;
                init_w2 = 16'h7FFF;
            end
            if (glitch_at > 0 && n == glitch_at + 1) begin
                start = 1'b0;
                load(v);
            end
            if (done) begin
                lat = n;
                break;
            end
        end
        if (lat == 0) begin
            tests++;
            fails++;
            $display("FAIL %s timeout: no done within %0d cycles", v.name, LIMIT);
            start = 1'b0;
            return;
        end
        check({v.name, " done latency"}, 32'(lat), 32'(v.lat));
        check({v.name, " converged"}, 32'(converged), 32'(v.conv));
        check({v.name, " epoch_count"}, 32'(epoch_count), 32'(v.epochs));
        if (v.conv) check({v.name, " err_count"}, 32'(err_count), 32'd0);
        else        check({v.name, " err_count nonzero"}, 32'(err_count != 0), 32'd1);
        if (v.chk_w) begin
            check({v.name, " w0"}, 32'(w0), 32'(v.ew0));
            check({v.name, " w1"}, 32'(w1), 32'(v.ew1));
            check({v.name, " w2"}, 32'(w2), 32'(v.ew2));
        end
        @(negedge clk);
        check({v.name, " done one cycle"}, 32'(done), 32'd0);
        check({v.name, " busy cleared"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int done_seen;
        tests = 0;
        fails = 0;

        tbl[0] = '{name: "or", in1: {16'h1000, 16'h0000, 16'h1000, 16'h0000},
                   in2: {16'h1000, 16'h1000, 16'h0000, 16'h0000},
                   d:   {16'h1000, 16'h1000, 16'h1000, 16'h0000},
                   iw0: 16'h8800, iw1: 16'h0800, iw2: 16'h0800,
                   conv: 1'b1, epochs: 1, chk_w: 1'b1,
                   ew0: 16'h8800, ew1: 16'h0800, ew2: 16'h0800, lat: 14};
        tbl[1] = '{name: "and", in1: {16'h1000, 16'h0000, 16'h1000, 16'h0000},
                   in2: {16'h1000, 16'h1000, 16'h0000, 16'h0000},
                   d:   {16'h1000, 16'h0000, 16'h0000, 16'h0000},
                   iw0: 16'h8800, iw1: 16'h0800, iw2: 16'h0800,
                   conv: 1'b1, epochs: 5, chk_w: 1'b1,
                   ew0: 16'h9800, ew1: 16'h0800, ew2: 16'h1000, lat: 66};
        tbl[2] = '{name: "xor", in1: {16'h1000, 16'h0000, 16'h1000, 16'h0000},
                   in2: {16'h1000, 16'h1000, 16'h0000, 16'h0000},
                   d:   {16'h0000, 16'h1000, 16'h1000, 16'h0000},
                   iw0: 16'h0000, iw1: 16'h0000, iw2: 16'h0000,
                   conv: 1'b0, epochs: 8, chk_w: 1'b0,
                   ew0: 16'h0000, ew1: 16'h0000, ew2: 16'h0000, lat: 105};

        adds[0] = '{a: 16'h7FF0, b: 16'h0800, exp: 16'h7FFF};
        adds[1] = '{a: 16'h8800, b: 16'h1000, exp: 16'h0800};
        adds[2] = '{a: 16'h8800, b: 16'h0800, exp: 16'h0000};
        adds[3] = '{a: 16'hFFF0, b: 16'h8800, exp: 16'hFFFF};
        adds[4] = '{a: 16'h8000, b: 16'h0800, exp: 16'h0800};
        adds[5] = '{a: 16'h8000, b: 16'h8000, exp: 16'h0000};

        rst   = 1'b1;
        start = 1'b0;
        load(tbl[0]);
        ua = '0;
        ub = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset w0", 32'(w0), 32'd0);
        check("reset w1", 32'(w1), 32'd0);
        check("reset w2", 32'(w2), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset converged", 32'(converged), 32'd0);
        check("reset epoch_count", 32'(epoch_count), 32'd0);
        check("reset err_count", 32'(err_count), 32'd0);

        for (int i = 0; i < 3; i++) run_case(i, 0);

        for (int i = 0; i < 6; i++) begin
            ua = adds[i].a;
            ub = adds[i].b;
            #1;
            check($sformatf("add %h+%h", adds[i].a, adds[i].b), 32'(us), 32'(adds[i].exp));
        end

        // start pulsed mid-epoch with different initial weights must be ignored
        run_case(1, 5);

        // rst during SETTLE of epoch 2
        @(negedge clk);
        load(tbl[1]);
        start = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("epoch 2 reached before rst", 32'(epoch_count), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst w0", 32'(w0), 32'd0);
        check("rst w1", 32'(w1), 32'd0);
        check("rst w2", 32'(w2), 32'd0);
        check("rst epoch_count", 32'(epoch_count), 32'd0);
        done_seen = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (done || busy) done_seen = 1;
        end
        check("no activity after rst", 32'(done_seen), 32'd0);

        run_case(1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
